// File: rtl/rast_pkg.sv
// Shared types for the triangle fetch/setup/scan controller.
//   coord_t  : signed screen/raw coordinate
//   vertex_t : packed {y, x}, so a vertex concatenation reads {vNy, vNx}
//   bbox_t   : packed {max_v, min_v} bounding box
//   state_e  : controller states
// Helpers: signed min/max and a clamp into [0, hi].
package rast_pkg;

  localparam int COORD_W       = 11;
  localparam int COLOR_W       = 8;
  localparam int VERTS_PER_TRI = 3;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t y;
    coord_t x;
  } vertex_t;

  typedef struct packed {
    vertex_t max_v;
    vertex_t min_v;
  } bbox_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_NEXT, S_FETCH, S_BBOX, S_CLIP, S_SCAN, S_DONE
  } state_e;

  function automatic coord_t cmin(coord_t a, coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t cmax(coord_t a, coord_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic coord_t clamp(coord_t v, coord_t hi);
    coord_t r;
    if (v[COORD_W-1]) r = '0;
    else if (v > hi)  r = hi;
    else              r = v;
    return r;
  endfunction

endpackage

// File: rtl/tri_scan_ctrl_bbox_clip.sv
// Bounding-box setup for one triangle, two register stages.
//   Stage 1: signed min/max over the three vertices plus the offscreen flag
//            (the flag uses the unclamped box).
//   Stage 2: clamp the box into the visible screen.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   v1_i, v2_i, v3_i    triangle vertices in screen coordinates
//   box_o               clamped box, valid 2 cycles after the vertices
//   offscreen_o         box lies fully outside the screen, same latency
module bbox_clip
  import rast_pkg::*;
#(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600
) (
  input  logic    clk,
  input  logic    reset,
  input  vertex_t v1_i,
  input  vertex_t v2_i,
  input  vertex_t v3_i,
  output bbox_t   box_o,
  output logic    offscreen_o
);

  localparam coord_t X_MAX = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_MAX = coord_t'(SCREEN_H - 1);

  bbox_t raw_q;
  logic  off_q;

  // Stage 1: raw extent of the triangle and the offscreen test on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q <= '0;
      off_q <= 1'b0;
    end else begin
      raw_q.min_v.x <= cmin(cmin(v1_i.x, v2_i.x), v3_i.x);
      raw_q.min_v.y <= cmin(cmin(v1_i.y, v2_i.y), v3_i.y);
      raw_q.max_v.x <= cmax(cmax(v1_i.x, v2_i.x), v3_i.x);
      raw_q.max_v.y <= cmax(cmax(v1_i.y, v2_i.y), v3_i.y);
      off_q <= cmax(cmax(v1_i.x, v2_i.x), v3_i.x) < coord_t'(0)
            || cmax(cmax(v1_i.y, v2_i.y), v3_i.y) < coord_t'(0)
            || cmin(cmin(v1_i.x, v2_i.x), v3_i.x) > X_MAX
            || cmin(cmin(v1_i.y, v2_i.y), v3_i.y) > Y_MAX;
    end
  end

  // Stage 2: clamp into the screen and forward the offscreen flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      box_o       <= '0;
      offscreen_o <= 1'b0;
    end else begin
      box_o.min_v.x <= clamp(raw_q.min_v.x, X_MAX);
      box_o.min_v.y <= clamp(raw_q.min_v.y, Y_MAX);
      box_o.max_v.x <= clamp(raw_q.max_v.x, X_MAX);
      box_o.max_v.y <= clamp(raw_q.max_v.y, Y_MAX);
      offscreen_o   <= off_q;
    end
  end

endmodule

// File: rtl/tri_scan_ctrl.sv
// Triangle fetch/setup/scan controller. It reads triangles from vertex BRAM,
// builds a clipped bounding box for each one and streams (x, y, colour) beats
// to the rasterizer. An optional full-screen clear pass can run first.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   start_i                        start pulse, accepted only when idle
//   vertex_count_i                 number of BRAM words in the list
//   clear_en_i, clear_color_i      clear pass enable and colour
//   mem_addr_o / mem_rdata_i       BRAM read port, data valid 1 cycle after the address
//   tri_v_o                        {v3y,v3x,v2y,v2x,v1y,v1x} of the current triangle
//   pix_x_o, pix_y_o, pix_color_o  beat payload
//   pix_clear_o, pix_last_o        beat flags
//   pix_valid_o / pix_ready_i      beat handshake
//   busy_o, done_o, tri_count_o    status
module tri_scan_ctrl
  import rast_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int STRIDE   = 4,
  parameter int ORIGIN_X = 400,
  parameter int ORIGIN_Y = 300
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [31:0]            vertex_count_i,
  input  logic                   clear_en_i,
  input  logic [COLOR_W-1:0]     clear_color_i,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic [COORD_W-1:0]     mem_rdata_i,
  output logic [6*COORD_W-1:0]   tri_v_o,
  output logic [COORD_W-1:0]     pix_x_o,
  output logic [COORD_W-1:0]     pix_y_o,
  output logic [COLOR_W-1:0]     pix_color_o,
  output logic                   pix_clear_o,
  output logic                   pix_last_o,
  output logic                   pix_valid_o,
  input  logic                   pix_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [15:0]            tri_count_o
);

  localparam int TRI_WORDS = VERTS_PER_TRI * STRIDE;

  state_e               state_q;
  logic [ADDR_W-1:0]    mem_addr_q, base_q;
  logic [31:0]          rem_q;
  logic [2:0]           fcnt_q;
  vertex_t              v1_q, v2_q, v3_q;
  bbox_t                box_q;
  coord_t               pix_x_q, pix_y_q;
  logic [COLOR_W-1:0]   pix_color_q, color_q;
  logic                 pix_clear_q, pix_last_q, pix_valid_q;
  logic                 busy_q, done_q;
  logic [15:0]          tri_count_q;

  coord_t               nx_d, ny_d, cap_x_d, cap_y_d;
  logic                 nlast_d;
  bbox_t                clip_box;
  logic                 clip_off;

  // Only words 0 and 1 of each vertex are read: fetch index k maps to
  // vertex k/2, word k%2.
  function automatic logic [ADDR_W-1:0] word_addr(logic [ADDR_W-1:0] base, logic [2:0] k);
    return base + ADDR_W'(int'(k[2:1]) * STRIDE) + ADDR_W'(k[0]);
  endfunction

  bbox_clip #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_bbox_clip (
    .clk         (clk),
    .reset       (reset),
    .v1_i        (v1_q),
    .v2_i        (v2_q),
    .v3_i        (v3_q),
    .box_o       (clip_box),
    .offscreen_o (clip_off)
  );

  assign cap_x_d = coord_t'(mem_rdata_i) + coord_t'(ORIGIN_X);
  assign cap_y_d = coord_t'(mem_rdata_i) + coord_t'(ORIGIN_Y);

  // Next raster position inside the current box (x fastest) and its last flag.
  always_comb begin
    nx_d = pix_x_q;
    ny_d = pix_y_q;
    if (pix_x_q == box_q.max_v.x) begin
      nx_d = box_q.min_v.x;
      ny_d = pix_y_q + coord_t'(1);
    end else begin
      nx_d = pix_x_q + coord_t'(1);
    end
    nlast_d = (nx_d == box_q.max_v.x) && (ny_d == box_q.max_v.y);
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      base_q      <= '0;
      rem_q       <= '0;
      fcnt_q      <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      v3_q        <= '0;
      box_q       <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      color_q     <= '0;
      pix_clear_q <= 1'b0;
      pix_last_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tri_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q      <= 1'b1;
            tri_count_q <= '0;
            color_q     <= COLOR_W'(1);
            base_q      <= '0;
            rem_q       <= vertex_count_i;
            if (clear_en_i) begin
              box_q.min_v.x <= '0;
              box_q.min_v.y <= '0;
              box_q.max_v.x <= coord_t'(SCREEN_W - 1);
              box_q.max_v.y <= coord_t'(SCREEN_H - 1);
              pix_x_q       <= '0;
              pix_y_q       <= '0;
              pix_color_q   <= clear_color_i;
              pix_clear_q   <= 1'b1;
              pix_last_q    <= (SCREEN_W == 1) && (SCREEN_H == 1);
              pix_valid_q   <= 1'b1;
              state_q       <= S_CLEAR;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        // The clear pass is an ordinary scan over the whole screen.
        S_CLEAR, S_SCAN: begin
          if (pix_valid_q && pix_ready_i) begin
            if (pix_last_q) begin
              pix_valid_q <= 1'b0;
              pix_last_q  <= 1'b0;
              pix_clear_q <= 1'b0;
              state_q     <= S_NEXT;
            end else begin
              pix_x_q    <= nx_d;
              pix_y_q    <= ny_d;
              pix_last_q <= nlast_d;
            end
          end
        end
        S_NEXT: begin
          if (rem_q >= 32'(TRI_WORDS)) begin
            mem_addr_q <= base_q;
            fcnt_q     <= '0;
            state_q    <= S_FETCH;
          end else begin
            state_q <= S_DONE;
          end
        end
        // Cycle k presents address k (k<6) and captures the word of address k-1.
        S_FETCH: begin
          case (fcnt_q)
            3'd1:    v1_q.x <= cap_x_d;
            3'd2:    v1_q.y <= cap_y_d;
            3'd3:    v2_q.x <= cap_x_d;
            3'd4:    v2_q.y <= cap_y_d;
            3'd5:    v3_q.x <= cap_x_d;
            3'd6:    v3_q.y <= cap_y_d;
            default: ;
          endcase
          if (fcnt_q < 3'd5) begin
            mem_addr_q <= word_addr(base_q, fcnt_q + 3'd1);
          end
          if (fcnt_q == 3'd6) begin
            base_q  <= base_q + ADDR_W'(TRI_WORDS);
            rem_q   <= rem_q - 32'(TRI_WORDS);
            fcnt_q  <= '0;
            state_q <= S_BBOX;
          end else begin
            fcnt_q <= fcnt_q + 3'd1;
          end
        end
        // Wait out the two register stages of bbox_clip.
        S_BBOX: begin
          if (fcnt_q == 3'd1) begin
            fcnt_q  <= '0;
            state_q <= S_CLIP;
          end else begin
            fcnt_q <= fcnt_q + 3'd1;
          end
        end
        // Colour index advances for skipped triangles too.
        S_CLIP: begin
          color_q <= color_q + COLOR_W'(1);
          if (clip_off) begin
            state_q <= S_NEXT;
          end else begin
            box_q       <= clip_box;
            pix_x_q     <= clip_box.min_v.x;
            pix_y_q     <= clip_box.min_v.y;
            pix_color_q <= color_q;
            pix_clear_q <= 1'b0;
            pix_last_q  <= (clip_box.min_v.x == clip_box.max_v.x)
                        && (clip_box.min_v.y == clip_box.max_v.y);
            pix_valid_q <= 1'b1;
            tri_count_q <= tri_count_q + 16'd1;
            state_q     <= S_SCAN;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign tri_v_o     = {v3_q, v2_q, v1_q};
  assign pix_x_o     = pix_x_q;
  assign pix_y_o     = pix_y_q;
  assign pix_color_o = pix_color_q;
  assign pix_clear_o = pix_clear_q;
  assign pix_last_o  = pix_last_q;
  assign pix_valid_o = pix_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign tri_count_o = tri_count_q;

endmodule

// File: tb/tb_tri_scan_ctrl.sv
// Directed bench for tri_scan_ctrl on a 16x8 screen, origin 0/0, stride 4.
module tb_tri_scan_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  vertex_count;
  logic         clear_en;
  logic [7:0]   clear_color;
  logic [13:0]  mem_addr;
  logic [10:0]  mem_rdata;
  logic [65:0]  tri_v;
  logic [10:0]  pix_x, pix_y;
  logic [7:0]   pix_color;
  logic         pix_clear, pix_last, pix_valid, pix_ready;
  logic         busy, done;
  logic [15:0]  tri_count;

  always #5 clk = ~clk;

  tri_scan_ctrl #(
    .ADDR_W(14), .SCREEN_W(16), .SCREEN_H(8), .STRIDE(4), .ORIGIN_X(0), .ORIGIN_Y(0)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start), .vertex_count_i(vertex_count),
    .clear_en_i(clear_en), .clear_color_i(clear_color),
    .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata), .tri_v_o(tri_v),
    .pix_x_o(pix_x), .pix_y_o(pix_y), .pix_color_o(pix_color),
    .pix_clear_o(pix_clear), .pix_last_o(pix_last), .pix_valid_o(pix_valid),
    .pix_ready_i(pix_ready), .busy_o(busy), .done_o(done), .tri_count_o(tri_count)
  );

  // Vertex BRAM model with one cycle read latency.
  logic [10:0] mem [0:63];
  always @(posedge clk) mem_rdata <= mem[mem_addr[5:0]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat(logic clr, logic lst, logic [7:0] col,
                                       logic [10:0] x, logic [10:0] y);
    return {clr, lst, col, x, y};
  endfunction

  // Ready generator: always 1, or toggling every cycle.
  logic tog_mode = 1'b0;
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tog_mode) pix_ready = ~pix_ready;
      else          pix_ready = 1'b1;
    end
  end

  // Monitor: accepted beats, stall stability, done pulses, address changes.
  logic [31:0] got_q[$];
  logic [13:0] addr_log[$];
  int          done_cnt = 0;
  int          stall_err = 0;
  initial begin
    logic        stall_p = 1'b0;
    logic [31:0] prev = 32'd0;
    logic [31:0] cur;
    logic [13:0] last_addr = 14'd0;
    forever begin
      @(negedge clk);
      cur = beat(pix_clear, pix_last, pix_color, pix_x, pix_y);
      if (stall_p && (!pix_valid || cur != prev)) stall_err++;
      stall_p = pix_valid && !pix_ready;
      prev = cur;
      if (pix_valid && pix_ready) got_q.push_back(cur);
      if (done) done_cnt++;
      if (mem_addr != last_addr) begin
        addr_log.push_back(mem_addr);
        last_addr = mem_addr;
      end
    end
  end

  logic [31:0] exp_q[$];
  int g0, d0, a0;

  task automatic mem_fill();
    for (int i = 0; i < 64; i++) mem[i] = 11'h055;
  endtask

  task automatic put_vtx(input int addr, input int x, input int y);
    mem[addr]     = 11'(x);
    mem[addr + 1] = 11'(y);
  endtask

  task automatic add_box(input int x0, input int x1, input int y0, input int y1,
                         input logic [7:0] col, input logic clr);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        exp_q.push_back(beat(clr, (x == x1) && (y == y1), col, 11'(x), 11'(y)));
  endtask

  task automatic snap();
    g0 = got_q.size();
    d0 = done_cnt;
    a0 = addr_log.size();
    exp_q.delete();
  endtask

  task automatic do_start(input logic [31:0] cnt, input logic cen, input logic [7:0] col);
    @(posedge clk); #1;
    vertex_count = cnt; clear_en = cen; clear_color = col; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic cmp_beats(input string tag);
    int n = got_q.size() - g0;
    check({tag, "_beat_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check({tag, "_beat"}, got_q[g0 + i], exp_q[i]);
  endtask

  task automatic load_tri2();
    mem_fill();
    put_vtx(0, 2, 1); put_vtx(4, 5, 1); put_vtx(8, 2, 3);
  endtask

  initial begin
    int exp_addr[5] = '{1, 4, 5, 8, 9};
    int n;
    reset = 1'b1; start = 1'b0; vertex_count = 32'd0; clear_en = 1'b0; clear_color = 8'd0;
    mem_fill();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_addr", mem_addr, 14'd0);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tri_count", tri_count, 16'd0);
    check("rst_tri_v", tri_v, 66'd0);
    check("rst_pix", {pix_x, pix_y, pix_color, pix_clear, pix_last}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Test 1: clear pass only.
    snap();
    add_box(0, 15, 0, 7, 8'hA5, 1'b1);
    do_start(32'd0, 1'b1, 8'hA5);
    @(negedge clk);
    check("t1_busy", busy, 1'b1);
    wait_done("t1", 2000);
    check("t1_busy_at_done", busy, 1'b0);
    cmp_beats("t1");
    check("t1_tri_count", tri_count, 16'd0);
    check("t1_done_pulses", done_cnt - d0, 1);

    // Test 2: one triangle, fetch address order.
    load_tri2();
    snap();
    add_box(2, 5, 1, 3, 8'd1, 1'b0);
    do_start(32'd12, 1'b0, 8'h00);
    wait_done("t2", 2000);
    cmp_beats("t2");
    check("t2_tri_count", tri_count, 16'd1);
    check("t2_tri_v", tri_v, {11'd3, 11'd2, 11'd1, 11'd5, 11'd1, 11'd2});
    check("t2_addr_changes", addr_log.size() - a0, 5);
    for (int i = 0; i < 5 && a0 + i < addr_log.size(); i++)
      check("t2_addr", addr_log[a0 + i], 14'(exp_addr[i]));

    // Test 3: stalled downstream plus an ignored start while busy.
    snap();
    add_box(2, 5, 1, 3, 8'd1, 1'b0);
    tog_mode = 1'b1;
    do_start(32'd12, 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #1 clear_en = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t3", 2000);
    tog_mode = 1'b0;
    cmp_beats("t3");
    check("t3_stall_stable", stall_err, 0);
    check("t3_tri_count", tri_count, 16'd1);
    check("t3_done_pulses", done_cnt - d0, 1);

    // Test 4: clamped box, offscreen skip, colour keeps counting.
    mem_fill();
    put_vtx(0, -5, -5);  put_vtx(4, 20, -2);  put_vtx(8, 3, 12);
    put_vtx(12, -9, -9); put_vtx(16, -3, -2); put_vtx(20, -1, -1);
    put_vtx(24, 1, 1);   put_vtx(28, 2, 1);   put_vtx(32, 1, 2);
    snap();
    add_box(0, 15, 0, 7, 8'd1, 1'b0);
    add_box(1, 2, 1, 2, 8'd3, 1'b0);
    do_start(32'd36, 1'b0, 8'h00);
    wait_done("t4", 3000);
    cmp_beats("t4");
    check("t4_tri_count", tri_count, 16'd2);
    check("t4_tri_v", tri_v, {11'd2, 11'd1, 11'd1, 11'd2, 11'd1, 11'd1});

    // Test 5a: too few words for a triangle.
    snap();
    do_start(32'd11, 1'b0, 8'h00);
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      @(negedge clk);
      if (done) n = i + 1;
    end
    check("t5a_done_latency_ok", (n >= 1) && (n <= 3), 1'b1);
    check("t5a_no_beats", got_q.size() - g0, 0);
    check("t5a_no_fetch", addr_log.size() - a0, 0);
    check("t5a_tri_count", tri_count, 16'd0);

    // Test 5b: 25 words -> two triangles, single row and single column boxes.
    mem_fill();
    put_vtx(0, 0, 0);  put_vtx(4, 1, 0);  put_vtx(8, 0, 0);
    put_vtx(12, 3, 2); put_vtx(16, 3, 5); put_vtx(20, 3, 4);
    mem[24] = 11'd7;
    snap();
    add_box(0, 1, 0, 0, 8'd1, 1'b0);
    add_box(3, 3, 2, 5, 8'd2, 1'b0);
    do_start(32'd25, 1'b0, 8'h00);
    wait_done("t5b", 2000);
    cmp_beats("t5b");
    check("t5b_tri_count", tri_count, 16'd2);

    // Test 6: reset in the middle of a scan, then a clean rerun.
    load_tri2();
    snap();
    do_start(32'd12, 1'b0, 8'h00);
    n = 0;
    for (int i = 0; i < 100 && n == 0; i++) begin
      @(negedge clk);
      if (pix_valid) n = 1;
    end
    check("t6_scan_reached", n, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_pix_valid", pix_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    @(posedge clk); #1 reset = 1'b0;
    snap();
    add_box(2, 5, 1, 3, 8'd1, 1'b0);
    do_start(32'd12, 1'b0, 8'h00);
    wait_done("t6", 2000);
    cmp_beats("t6");
    check("t6_tri_count", tri_count, 16'd1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
